mem_arbiter: RTL and testbench

The arbiter shares the core's single Avalon-MM host port between the instruction-fetch unit (read-only) and the load/store unit (read/write).

- It sits between the IF/MEM pipeline stages and the system bus.
- It holds the granted command stable while the slave asserts waitrequest.
- It tracks outstanding reads so each in-order `readdatavalid` beat goes back to the requester that issued it.
- LSU has fixed priority. A starvation counter guarantees IF forward progress.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/owner_fifo.sv | 65 ++++++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/LSU Avalon-MM host-port arbiter.
// Owner ids tag every in-flight read so its response can be routed back.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD_IF = 2'd1,
    ST_HOLD_LS = 2'd2
  } arb_state_e;

  typedef logic owner_t;

  localparam owner_t     OWNER_IF = 1'b0;
  localparam owner_t     OWNER_LS = 1'b1;
  localparam logic [3:0] BE_ALL   = 4'hF;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } bus_cmd_t;

  function automatic arb_state_e hold_state(input owner_t owner);
    return (owner == OWNER_LS) ? ST_HOLD_LS : ST_HOLD_IF;
  endfunction

endpackage

// File: rtl/owner_fifo.sv
// Small synchronous FIFO recording which requester issued each outstanding read.
// Push and pop may coincide; a pop while empty or push while full is ignored.
module owner_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the occupancy counter alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one Avalon-MM host port between instruction fetch (read-only) and the LSU.
// LSU has fixed priority; a saturating starvation counter guarantees IF progress.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        if_read,
  input  logic [31:0] if_address,
  output logic        if_waitrequest,
  output logic [31:0] if_readdata,
  output logic        if_readdatavalid,
  input  logic        ls_read,
  input  logic        ls_write,
  input  logic [31:0] ls_address,
  input  logic [31:0] ls_writedata,
  input  logic [3:0]  ls_byteenable,
  output logic        ls_waitrequest,
  output logic [31:0] ls_readdata,
  output logic        ls_readdatavalid,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_address,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e      state_q, state_d;
  logic [SC_W-1:0] starve_q, starve_d;

  owner_t   owner;
  bus_cmd_t if_cmd, ls_cmd, sel_cmd;
  logic     ls_req, starved, blocked, cmd_valid, accepted;
  logic     fifo_full, fifo_empty, fifo_push;
  owner_t   fifo_head;

  assign ls_req  = ls_read | ls_write;
  assign starved = (starve_q == SC_W'(STARVE_LIMIT)) & if_read;

  assign if_cmd = '{read: if_read, write: 1'b0, address: if_address,
                    writedata: '0, byteenable: BE_ALL};
  assign ls_cmd = '{read: ls_read, write: ls_write, address: ls_address,
                    writedata: ls_writedata, byteenable: ls_byteenable};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Owner selection, command mux and requester handshakes.
  always_comb begin
    owner = OWNER_IF;
    unique case (state_q)
      ST_HOLD_IF: owner = OWNER_IF;
      ST_HOLD_LS: owner = OWNER_LS;
      default:    owner = (ls_req & ~starved) ? OWNER_LS : OWNER_IF;
    endcase

    sel_cmd   = (owner == OWNER_LS) ? ls_cmd : if_cmd;
    blocked   = sel_cmd.read & fifo_full;
    cmd_valid = (sel_cmd.read & ~blocked) | sel_cmd.write;
    accepted  = cmd_valid & ~avm_waitrequest;

    avm_read       = sel_cmd.read & ~blocked;
    avm_write      = sel_cmd.write;
    avm_address    = cmd_valid ? sel_cmd.address    : '0;
    avm_writedata  = cmd_valid ? sel_cmd.writedata  : '0;
    avm_byteenable = cmd_valid ? sel_cmd.byteenable : '0;

    if_waitrequest = ~((owner == OWNER_IF) & if_read & ~avm_waitrequest & ~blocked);
    ls_waitrequest = ~((owner == OWNER_LS) & ls_req  & ~avm_waitrequest & ~blocked);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (cmd_valid && avm_waitrequest) state_d = hold_state(owner);
      ST_HOLD_IF,
      ST_HOLD_LS: if (accepted) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Counts consecutive IF denials, saturating so the priority flip is sticky.
  always_comb begin
    starve_d = starve_q;
    if (!if_waitrequest)
      starve_d = '0;
    else if (if_read && starve_q != SC_W'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end

  assign fifo_push = avm_read & ~avm_waitrequest;

  owner_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (1)
  ) u_owner_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (fifo_push),
    .push_data (owner),
    .pop       (avm_readdatavalid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign if_readdata      = avm_readdata;
  assign ls_readdata      = avm_readdata;
  assign if_readdatavalid = avm_readdatavalid & ~fifo_empty & (fifo_head == OWNER_IF);
  assign ls_readdatavalid = avm_readdatavalid & ~fifo_empty & (fifo_head == OWNER_LS);

  a_no_orphan_beat: assert property (@(posedge clk) disable iff (!rst_b)
    avm_readdatavalid |-> !fifo_empty)
    else $warning("mem_arbiter: read beat with no outstanding read dropped");

  a_if_holds: assert property (@(posedge clk) disable iff (!rst_b)
    (state_q == ST_HOLD_IF) |-> if_read)
    else $error("mem_arbiter: IF dropped its read while held");

  a_ls_holds: assert property (@(posedge clk) disable iff (!rst_b)
    (state_q == ST_HOLD_LS) |-> ls_req)
    else $error("mem_arbiter: LSU dropped its command while held");

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner
// sequences, then randomized traffic compared against a queue-based reference model.
module tb_mem_arbiter;

  localparam int OUTSTANDING  = 2;
  localparam int STARVE_LIMIT = 8;
  localparam int RND_CYCLES   = 2000;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        if_read = 1'b0;
  logic [31:0] if_address = '0;
  logic        if_waitrequest;
  logic [31:0] if_readdata;
  logic        if_readdatavalid;
  logic        ls_read = 1'b0, ls_write = 1'b0;
  logic [31:0] ls_address = '0, ls_writedata = '0;
  logic [3:0]  ls_byteenable = '0;
  logic        ls_waitrequest;
  logic [31:0] ls_readdata;
  logic        ls_readdatavalid;
  logic        avm_read, avm_write;
  logic [31:0] avm_address, avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .OUTSTANDING  (OUTSTANDING),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk               (clk),
    .rst_b             (rst_b),
    .if_read           (if_read),
    .if_address        (if_address),
    .if_waitrequest    (if_waitrequest),
    .if_readdata       (if_readdata),
    .if_readdatavalid  (if_readdatavalid),
    .ls_read           (ls_read),
    .ls_write          (ls_write),
    .ls_address        (ls_address),
    .ls_writedata      (ls_writedata),
    .ls_byteenable     (ls_byteenable),
    .ls_waitrequest    (ls_waitrequest),
    .ls_readdata       (ls_readdata),
    .ls_readdatavalid  (ls_readdatavalid),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_address       (avm_address),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic lr, input logic lw, input logic [31:0] la,
                       input logic [31:0] lwd, input logic [3:0] lbe,
                       input logic wt, input logic rdv, input logic [31:0] rd);
    if_read = ir;  if_address = ia;
    ls_read = lr;  ls_write = lw;  ls_address = la;
    ls_writedata = lwd;  ls_byteenable = lbe;
    avm_waitrequest = wt;  avm_readdatavalid = rdv;  avm_readdata = rd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic expect_cmd(input string tag, input logic e_rd, input logic e_wr,
                            input logic [31:0] e_addr, input logic [31:0] e_wd,
                            input logic [3:0] e_be, input logic e_iw, input logic e_lw);
    check({tag, ".avm_read"},       32'(avm_read),       32'(e_rd));
    check({tag, ".avm_write"},      32'(avm_write),      32'(e_wr));
    check({tag, ".avm_address"},    avm_address,         e_addr);
    check({tag, ".avm_writedata"},  avm_writedata,       e_wd);
    check({tag, ".avm_byteenable"}, 32'(avm_byteenable), 32'(e_be));
    check({tag, ".if_waitrequest"}, 32'(if_waitrequest), 32'(e_iw));
    check({tag, ".ls_waitrequest"}, 32'(ls_waitrequest), 32'(e_lw));
  endtask

  task automatic expect_rsp(input string tag, input logic e_ir, input logic e_lr,
                            input logic [31:0] e_data);
    check({tag, ".if_readdatavalid"}, 32'(if_readdatavalid), 32'(e_ir));
    check({tag, ".ls_readdatavalid"}, 32'(ls_readdatavalid), 32'(e_lr));
    if (e_ir || e_lr) begin
      check({tag, ".if_readdata"}, if_readdata, e_data);
      check({tag, ".ls_readdata"}, ls_readdata, e_data);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        if_rd;
    logic [31:0] if_addr;
    logic        ls_rd, ls_wr;
    logic [31:0] ls_addr, ls_wd;
    logic [3:0]  ls_be;
    logic        wt, rdv;
    logic [31:0] rdata;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic        e_iw, e_lw, e_ir, e_lr;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    // Reference model state for the randomized phase.
    int     locked;
    bit     oq[$];
    int     starve;
    logic   if_pend, ls_pend, ls_isw;
    logic [31:0] if_a, ls_a, ls_wd;
    logic [3:0]  ls_be;

    // Consecutive cycles from reset: idle, IF read, response, LSU/IF collision.
    vecs[0] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE0001,
                1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h104, 1'b0, 1'b1, 32'h2000, 32'h55, 4'h3, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b1, 32'h2000, 32'h55, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 1'b0, 1'b1, 32'h11,
                1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h22,
                1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state
    idle();
    #12;
    expect_cmd("in_reset", 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    expect_rsp("in_reset", 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_b = 1'b1;
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].if_rd, vecs[i].if_addr, vecs[i].ls_rd, vecs[i].ls_wr, vecs[i].ls_addr,
            vecs[i].ls_wd, vecs[i].ls_be, vecs[i].wt, vecs[i].rdv, vecs[i].rdata);
      @(negedge clk);
      expect_cmd($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_addr,
                 vecs[i].e_wd, vecs[i].e_be, vecs[i].e_iw, vecs[i].e_lw);
      expect_rsp($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_lr, vecs[i].rdata);
      next_cycle();
    end

    // Slave stall on an LSU read while IF waits; command must stay frozen.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'h108, 1'b1, 1'b0, 32'h400, '0, 4'hF, (c < 3), 1'b0, '0);
      @(negedge clk);
      expect_cmd($sformatf("stall%0d", c), 1'b1, 1'b0, 32'h400, '0, 4'hF, 1'b1, (c < 3));
      next_cycle();
    end
    drive(1'b1, 32'h108, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    expect_cmd("stall_if", 1'b1, 1'b0, 32'h108, '0, 4'hF, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 32'hA1);
    @(negedge clk);
    expect_rsp("stall_rsp0", 1'b0, 1'b1, 32'hA1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 32'hA2);
    @(negedge clk);
    expect_rsp("stall_rsp1", 1'b1, 1'b0, 32'hA2);
    next_cycle();

    // Outstanding limit: third read is held until one response pops.
    drive(1'b1, 32'h500, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    expect_cmd("os_if0", 1'b1, 1'b0, 32'h500, '0, 4'hF, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, '0, 1'b1, 1'b0, 32'h600, '0, 4'hF, 1'b0, 1'b0, '0);
    @(negedge clk);
    expect_cmd("os_ls1", 1'b1, 1'b0, 32'h600, '0, 4'hF, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 32'h504, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    expect_cmd("os_full", 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 32'h504, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 32'hB1);
    @(negedge clk);
    expect_cmd("os_pop", 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    expect_rsp("os_pop", 1'b1, 1'b0, 32'hB1);
    next_cycle();
    drive(1'b1, 32'h504, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    expect_cmd("os_issue", 1'b1, 1'b0, 32'h504, '0, 4'hF, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 32'hB2);
    @(negedge clk);
    expect_rsp("os_rsp_ls", 1'b0, 1'b1, 32'hB2);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 32'hB3);
    @(negedge clk);
    expect_rsp("os_rsp_if", 1'b1, 1'b0, 32'hB3);
    next_cycle();

    // Starvation: continuous LSU writes, IF wins on its 9th requesting cycle.
    for (int c = 0; c <= STARVE_LIMIT; c++) begin
      drive(1'b1, 32'h700, 1'b0, 1'b1, 32'h3000 + 32'(4 * c), 32'(c), 4'hF, 1'b0, 1'b0, '0);
      @(negedge clk);
      if (c < STARVE_LIMIT)
        expect_cmd($sformatf("starve%0d", c), 1'b0, 1'b1, 32'h3000 + 32'(4 * c), 32'(c),
                   4'hF, 1'b1, 1'b0);
      else
        expect_cmd("starve_win", 1'b1, 1'b0, 32'h700, '0, 4'hF, 1'b0, 1'b1);
      next_cycle();
    end
    drive(1'b1, 32'h704, 1'b0, 1'b1, 32'h3020, 32'(STARVE_LIMIT), 4'hF, 1'b0, 1'b0, '0);
    @(negedge clk);
    expect_cmd("starve_clr", 1'b0, 1'b1, 32'h3020, 32'(STARVE_LIMIT), 4'hF, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 32'h704, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 32'hC1);
    @(negedge clk);
    expect_cmd("starve_if2", 1'b1, 1'b0, 32'h704, '0, 4'hF, 1'b0, 1'b1);
    expect_rsp("starve_if2", 1'b1, 1'b0, 32'hC1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 32'hC2);
    @(negedge clk);
    expect_rsp("starve_rsp", 1'b1, 1'b0, 32'hC2);
    next_cycle();

    // Reset with two reads in flight (LS at the head) clears routing state.
    drive(1'b0, '0, 1'b1, 1'b0, 32'h800, '0, 4'hF, 1'b0, 1'b0, '0);
    next_cycle();
    drive(1'b1, 32'h900, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    next_cycle();
    idle();
    rst_b = 1'b0;
    #2;
    expect_cmd("rst_mid", 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    expect_rsp("rst_mid", 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_b = 1'b1;
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 32'hD1);
    @(negedge clk);
    expect_cmd("rst_after", 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    expect_rsp("rst_drop", 1'b0, 1'b0, '0);
    next_cycle();
    drive(1'b1, 32'hA00, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    expect_cmd("rst_newrd", 1'b1, 1'b0, 32'hA00, '0, 4'hF, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 32'hD2);
    @(negedge clk);
    expect_rsp("rst_newrsp", 1'b1, 1'b0, 32'hD2);
    next_cycle();

    // Randomized traffic against a transaction-level model.
    locked = -1;  starve = 0;
    if_pend = 1'b0;  ls_pend = 1'b0;  ls_isw = 1'b0;
    if_a = '0;  ls_a = '0;  ls_wd = '0;  ls_be = '0;
    for (int n = 0; n < RND_CYCLES; n++) begin
      logic wt, rdv, e_rd, e_wr, rd, wr, acc, e_ir, e_lr, presented;
      logic [31:0] rdata, e_addr, e_wd;
      logic [3:0] e_be;
      int own;
      string tag;

      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        if_a = $urandom;
      end
      if (!ls_pend && $urandom_range(0, 1) == 0) begin
        ls_pend = 1'b1;
        ls_isw = 1'($urandom_range(0, 1));
        ls_a = $urandom;
        ls_wd = $urandom;
        ls_be = 4'($urandom_range(1, 15));
      end
      wt = ($urandom_range(0, 3) == 0);
      rdv = (oq.size() > 0) && ($urandom_range(0, 1) == 1);
      rdata = $urandom;
      drive(if_pend, if_a, ls_pend & ~ls_isw, ls_pend & ls_isw, ls_a, ls_wd, ls_be,
            wt, rdv, rdata);

      if (locked >= 0)                                       own = locked;
      else if (ls_pend && !(starve == STARVE_LIMIT && if_pend)) own = 1;
      else                                                   own = 0;
      rd = (own == 1) ? (ls_pend && !ls_isw) : if_pend;
      wr = (own == 1) && ls_pend && ls_isw;
      e_rd = rd && (oq.size() < OUTSTANDING);
      e_wr = wr;
      presented = e_rd || e_wr;
      acc = presented && !wt;
      e_addr = !presented ? 32'h0 : (own == 1) ? ls_a : if_a;
      e_wd   = (presented && own == 1) ? ls_wd : 32'h0;
      e_be   = !presented ? 4'h0 : (own == 1) ? ls_be : 4'hF;
      e_ir = rdv && (oq[0] == 1'b0);
      e_lr = rdv && (oq[0] == 1'b1);

      @(negedge clk);
      tag = $sformatf("rnd%0d", n);
      expect_cmd(tag, e_rd, e_wr, e_addr, e_wd, e_be,
                 !(acc && own == 0), !(acc && own == 1));
      expect_rsp(tag, e_ir, e_lr, rdata);
      next_cycle();

      if (rdv) void'(oq.pop_front());
      if (acc && e_rd) oq.push_back(bit'(own));
      if (acc && own == 0) starve = 0;
      else if (if_pend && starve < STARVE_LIMIT) starve++;
      if (acc) locked = -1;
      else if (presented) locked = own;
      if (acc && own == 0) if_pend = 1'b0;
      if (acc && own == 1) ls_pend = 1'b0;
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
